// File: rtl/com_rx_fifo.sv
// com_rx_fifo: first-word-fall-through receive byte buffer between the UART receiver and the serial controller,
// with a sticky overflow flag and an interrupt on fill threshold or idle timeout.
module com_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int THRESHOLD = 8,
    parameter int TIMEOUT   = 4000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rxdReady_i,
    input  logic [7:0]              rxdData_i,
    input  logic                    pop_i,
    input  logic                    clearOverflow_i,
    output logic [7:0]              data_o,
    output logic                    valid_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    overflow_o,
    output logic                    int_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          prev_q, armed_q, ovf_q, ovf_d, int_q, int_d;
    logic          push, pop_eff, push_eff;

    always_comb begin
        // armed_q blocks a strobe that was already high when reset released
        push     = rxdReady_i & ~prev_q & armed_q;
        pop_eff  = pop_i & (count_q != '0);
        push_eff = push & ((count_q != CW'(DEPTH)) | pop_eff);
        rd_d     = rd_q + AW'(pop_eff);
        wr_d     = wr_q + AW'(push_eff);
        count_d  = count_q + CW'(push_eff) - CW'(pop_eff);
        ovf_d    = (push & ~push_eff) | (ovf_q & ~clearOverflow_i);
        timer_d  = (push_eff | pop_eff | (count_q == '0)) ? '0 :
                   (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + TW'(1);
        int_d    = (count_q >= CW'(THRESHOLD)) | (timer_q == TW'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            timer_q <= '0;
            ovf_q   <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            prev_q  <= rxdReady_i;
            armed_q <= armed_q | ~rxdReady_i;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
            int_q   <= int_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_q] <= rxdData_i;
    end

    assign valid_o    = count_q != '0;
    assign data_o     = valid_o ? mem_q[rd_q] : 8'h00;
    assign count_o    = count_q;
    assign full_o     = count_q == CW'(DEPTH);
    assign overflow_o = ovf_q;
    assign int_o      = int_q;
endmodule

// File: tb/tb_com_rx_fifo.sv
// tb_com_rx_fifo: directed bench for com_rx_fifo with DEPTH=16, THRESHOLD=8, TIMEOUT=10.
module tb_com_rx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       rxdReady_i;
    logic [7:0] rxdData_i;
    logic       pop_i;
    logic       clearOverflow_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic [4:0] count_o;
    logic       full_o;
    logic       overflow_o;
    logic       int_o;
    int         checks = 0;
    int         errors = 0;

    com_rx_fifo #(.DEPTH(16), .THRESHOLD(8), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i),
        .pop_i(pop_i), .clearOverflow_i(clearOverflow_i), .data_o(data_o),
        .valid_o(valid_o), .count_o(count_o), .full_o(full_o),
        .overflow_o(overflow_o), .int_o(int_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input int w);
        rxdReady_i = 1'b1;
        rxdData_i  = b;
        repeat (w) @(negedge clk);
        rxdReady_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop1();
        pop_i = 1'b1;
        @(negedge clk);
        pop_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rxdReady_i = 1'b0; rxdData_i = 8'h00; pop_i = 1'b0; clearOverflow_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", count_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_int", int_o, 0);
        chk("rst_ovf", overflow_o, 0);
        rst = 1'b0;
        @(negedge clk);

        push_byte(8'h41, 3);
        push_byte(8'h42, 3);
        push_byte(8'h43, 3);
        chk("wide_strobe_count", count_o, 3);
        chk("head_41", data_o, 8'h41);
        chk("valid_3", valid_o, 1);
        pop1();
        chk("head_42", data_o, 8'h42);
        pop1();
        chk("head_43", data_o, 8'h43);
        pop1();
        chk("drained_valid", valid_o, 0);
        chk("drained_data", data_o, 8'h00);
        pop1();
        chk("pop_empty_count", count_o, 0);

        for (int i = 1; i <= 7; i++) push_byte(8'(i), 1);
        chk("thr_below_int", int_o, 0);
        rxdReady_i = 1'b1; rxdData_i = 8'd8;
        @(negedge clk);
        rxdReady_i = 1'b0;
        chk("thr_count8", count_o, 8);
        chk("thr_int_not_yet", int_o, 0);
        @(negedge clk);
        chk("thr_int_rise", int_o, 1);
        pop1();
        chk("thr_count7", count_o, 7);
        chk("thr_int_held", int_o, 1);
        @(negedge clk);
        chk("thr_int_fall", int_o, 0);
        for (int i = 2; i <= 8; i++) begin
            chk("thr_drain_data", data_o, 32'(i));
            pop1();
        end
        chk("thr_drained", count_o, 0);

        for (int i = 1; i <= 17; i++) push_byte(8'(8'h10 + i), 1);
        chk("ovf_count", count_o, 16);
        chk("ovf_full", full_o, 1);
        chk("ovf_flag", overflow_o, 1);
        chk("ovf_head", data_o, 8'h11);
        clearOverflow_i = 1'b1;
        @(negedge clk);
        clearOverflow_i = 1'b0;
        chk("ovf_cleared", overflow_o, 0);
        rxdReady_i = 1'b1; rxdData_i = 8'h99; pop_i = 1'b1;
        @(negedge clk);
        rxdReady_i = 1'b0; pop_i = 1'b0;
        chk("full_pushpop_count", count_o, 16);
        chk("full_pushpop_ovf", overflow_o, 0);
        for (int i = 2; i <= 17; i++) begin
            chk("full_drain_data", data_o, (i == 17) ? 32'h99 : 32'(8'h10 + i));
            pop1();
        end
        chk("full_drained", valid_o, 0);

        rxdReady_i = 1'b1; rxdData_i = 8'h55; pop_i = 1'b1;
        @(negedge clk);
        rxdReady_i = 1'b0; pop_i = 1'b0;
        chk("empty_pushpop_count", count_o, 1);
        chk("empty_pushpop_data", data_o, 8'h55);
        pop1();
        chk("empty_pushpop_drain", count_o, 0);

        rxdReady_i = 1'b1; rxdData_i = 8'h77;
        @(negedge clk);
        rxdReady_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("tmo_not_yet", int_o, 0);
        @(negedge clk);
        chk("tmo_fire", int_o, 1);
        pop1();
        chk("tmo_pop_count", count_o, 0);
        @(negedge clk);
        chk("tmo_cleared", int_o, 0);

        rxdReady_i = 1'b1; rxdData_i = 8'h61;
        @(negedge clk);
        rxdReady_i = 1'b0;
        repeat (5) @(negedge clk);
        rxdReady_i = 1'b1; rxdData_i = 8'h62;
        @(negedge clk);
        rxdReady_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("tmo_restart_quiet", int_o, 0);
        chk("tmo_restart_count", count_o, 2);
        @(negedge clk);
        chk("tmo_restart_fire", int_o, 1);
        pop1();
        pop1();
        chk("tmo_restart_drain", count_o, 0);

        for (int i = 0; i < 5; i++) push_byte(8'(8'hA0 + i), 1);
        chk("mid_count5", count_o, 5);
        rxdReady_i = 1'b1; rxdData_i = 8'hAA;
        rst = 1'b1;
        #1;
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_data", data_o, 0);
        chk("mid_rst_full", full_o, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_strobe_ignored", count_o, 0);
        rxdReady_i = 1'b0;
        @(negedge clk);
        rxdReady_i = 1'b1; rxdData_i = 8'hBB;
        @(negedge clk);
        rxdReady_i = 1'b0;
        chk("retoggle_count", count_o, 1);
        chk("retoggle_data", data_o, 8'hBB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/com_rx_fifo.md
# com_rx_fifo

Receive buffer between the UART receiver (`async_receiver`) and `serial_ctrl`. It captures each received byte on the rising edge of the receiver's ready strobe and holds up to DEPTH bytes in first-word-fall-through order. It exposes the head byte and occupancy to the serial controller, and raises an interrupt on a fill threshold or on an idle timeout. Without it, bytes arriving while the CPU is busy in an exception handler are lost.

## Interface
Parameters:
- DEPTH, 16: number of byte entries; must be a power of two, at least 2.
- THRESHOLD, 8: occupancy at or above which `int_o` asserts; range 1..DEPTH.
- TIMEOUT, 4000: idle cycles with a non-empty FIFO before the timeout interrupt fires; must be at least 1.

Ports:
- clk  in  1  system clock (clk25 domain).
- rst  in  1  reset; asynchronous, active-high.
- rxdReady_i  in  1  ready strobe from the receiver; only its rising edge is acted on.
- rxdData_i  in  8  received byte, valid while `rxdReady_i` is high.
- pop_i  in  1  consume the head byte; one byte per cycle that `pop_i` is high.
- clearOverflow_i  in  1  clears the sticky overflow flag.
- data_o  out  8  head byte; 8'h00 when the FIFO is empty.
- valid_o  out  1  FIFO holds at least one byte.
- count_o  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- full_o  out  1  count_o == DEPTH.
- overflow_o  out  1  sticky flag: a byte was dropped.
- int_o  out  1  interrupt request to the CPU (COM line).

## Operation
- Edge detect:
  - A registered copy of `rxdReady_i` (reset 0) is kept.
  - push = `rxdReady_i` & ~prev, so one push per strobe regardless of strobe width.
- Storage:
  - Circular buffer of DEPTH×8 bits.
  - Read pointer and write pointer are log2(DEPTH) bits each and wrap modulo DEPTH.
  - count is a separate register of log2(DEPTH)+1 bits.
- Pop is effective only if count > 0 (pop when empty is ignored); the read pointer advances.
- Push:
  - Effective if count < DEPTH, or if an effective pop happens in the same cycle.
  - Otherwise the byte is dropped, `overflow_o` is set, and the pointers and count are unchanged.
- Simultaneous events:
  - Push and pop while full: both take effect; count stays at DEPTH; no overflow.
  - Push and pop while empty: the pop is ignored and the push takes effect; count goes to 1.
  - Push and pop otherwise: both take effect; count is unchanged.
- overflow_o:
  - Set by a dropped push; cleared by `clearOverflow_i`.
  - If a set and a clear coincide, the set wins.
- Idle timer, log2(TIMEOUT)+1 bits:
  - Resets to 0 on any effective push or pop, and whenever count == 0.
  - Otherwise increments, saturating at TIMEOUT.
  - timeoutHit = (timer == TIMEOUT).
- int_o = (count_o >= THRESHOLD) | timeoutHit. It is level-sensitive and deasserts once popping brings the condition false.
- Reset mid-operation empties the FIFO immediately. Stored bytes are discarded, and a strobe that is high when reset releases is not captured until it falls and rises again.

## Timing
- Reset values:
  - `data_o`=0, `valid_o`=0, `count_o`=0, `full_o`=0, `overflow_o`=0, `int_o`=0.
  - Pointers, timer and edge register are 0.
- Latency from rising edge of `rxdReady_i` to the byte visible:
  - The push is registered at the first clk edge where `rxdReady_i`=1 and prev=0.
  - `valid_o`, `count_o` and `data_o` update after that edge.
- Pop: `data_o` shows the next byte (or 0) in the cycle after the edge that samples `pop_i`=1. Combinational read from storage is indexed by the read pointer.
- `int_o`: registered; asserts in the cycle after count reaches THRESHOLD or the timer reaches TIMEOUT.
- `count_o`, `full_o` and `valid_o` are registered or derived from registered count only; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then push 3 bytes (0x41, 0x42, 0x43) as 3-cycle strobes → count_o=3 (one push per strobe), data_o=0x41; pop ×3 → 0x42, 0x43, then valid_o=0 and data_o=0x00.
- THRESHOLD=8: push 8 bytes → `int_o` rises the cycle after the 8th push; pop 1 → `int_o` falls the next cycle.
- Overflow (DEPTH=16):
  - Push 17 bytes → count_o=16, full_o=1, overflow_o=1; the 17th byte is absent and 16 pops return bytes 1..16 in order.
  - Assert clearOverflow_i → overflow_o=0.
- Full + simultaneous: at count 16, push 0x99 with pop in the same cycle → count stays 16, no overflow; the last of the subsequent 16 pops returns 0x99. At count 0, push+pop in the same cycle → count=1.
- Timeout (TIMEOUT=10): push 1 byte, stay idle → `int_o` asserts in the cycle after the timer reaches 10; a pop clears it; a push at cycle 5 restarts the count.
- Reset mid-stream: with 5 bytes buffered and `rxdReady_i` held high, assert rst → all outputs go to 0 immediately; after release there is no push until `rxdReady_i` toggles low→high.
